doorbell_receiver: RTL and testbench

DOORBELL_RECEIVER -- requirements
Module: doorbell_receiver

---
 rtl/nvme_pcie_pkg.sv | 46 ++++
 rtl/db_addr_decode.sv | 44 ++++
 rtl/doorbell_receiver.sv | 188 ++++++++++++++++++
 tb/tb_doorbell_receiver.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvme_pcie_pkg.sv
// Shared definitions for the NVMe PCIe completer-request path.
// It holds the tuser bit positions, request-type codes, doorbell layout and FSM states.
package nvme_pcie_pkg;

    localparam int TUSER_FIRST_BE_LSB = 0;
    localparam int TUSER_LAST_BE_LSB  = 4;
    localparam int TUSER_SOP_BIT      = 40;
    localparam int TUSER_DISC_BIT     = 41;

    localparam logic [3:0] REQ_MEM_RD = 4'b0000;
    localparam logic [3:0] REQ_MEM_WR = 4'b0001;

    localparam logic [15:0] DB_BASE  = 16'h1000;
    localparam int          DB_IDX_W = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [13:0] dw_addr;
        logic [10:0] dword_count;
        logic [3:0]  first_be;
        logic [3:0]  last_be;
    } cq_desc_t;

    typedef struct packed {
        logic                hit;
        logic [DB_IDX_W-1:0] idx;
        logic [1:0]          be;
    } db_target_t;

    // Doorbells are 16 bits wide, so only byte lanes 0 and 1 can change them.
    function automatic logic [15:0] merge_db(input logic [15:0] cur,
                                             input logic [15:0] wdata,
                                             input logic [1:0]  be);
        logic [15:0] r;
        r = cur;
        if (be[0]) r[7:0]  = wdata[7:0];
        if (be[1]) r[15:8] = wdata[15:8];
        return r;
    endfunction

endpackage

// File: rtl/db_addr_decode.sv
// Maps a latched MemWr descriptor onto doorbell indices for the one or two dwords of its data beat.
// Even indices are SQ tails and odd indices are CQ heads; the doorbells are packed with zero stride.
module db_addr_decode
    import nvme_pcie_pkg::*;
#(
    parameter int NUM_QUEUES = 2
) (
    input  logic [13:0] dw_addr,
    input  logic [10:0] dword_count,
    input  logic [3:0]  first_be,
    input  logic [3:0]  last_be,
    input  logic [1:0]  keep,
    output db_target_t  dw0,
    output db_target_t  dw1
);

    localparam logic [DB_IDX_W-1:0] NUM_DB = DB_IDX_W'(2 * NUM_QUEUES);

    logic [15:0]         byte_off;
    logic [15:0]         rel_off;
    logic                below_base;
    logic [DB_IDX_W-1:0] idx0;
    logic [DB_IDX_W-1:0] idx1;
    logic                unused_bits;

    assign byte_off   = {dw_addr, 2'b00};
    assign below_base = byte_off < DB_BASE;
    assign rel_off    = byte_off - DB_BASE;
    assign idx0       = rel_off[15:2];
    assign idx1       = idx0 + DB_IDX_W'(1);

    assign dw0 = '{hit: !below_base && (idx0 < NUM_DB) && (|first_be[1:0]) && keep[0],
                   idx: idx0,
                   be:  first_be[1:0]};

    // The second dword exists only for two-dword writes and lands on the next doorbell.
    assign dw1 = '{hit: (dword_count == 11'd2) && !below_base && (idx1 < NUM_DB) &&
                        (|last_be[1:0]) && keep[1],
                   idx: idx1,
                   be:  last_be[1:0]};

    assign unused_bits = ^{first_be[3:2], last_be[3:2], rel_off[1:0]};

endmodule

// File: rtl/doorbell_receiver.sv
// Receives NVMe doorbell writes from the PCIe completer-request stream and keeps the SQ tail / CQ head registers.
// A doorbell write is one MemWr TLP: a descriptor beat, then one data beat carrying one or two dwords.
module doorbell_receiver
    import nvme_pcie_pkg::*;
#(
    parameter int C_DATA_WIDTH        = 128,
    parameter int AXI4_CQ_TUSER_WIDTH = 85,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int NUM_QUEUES          = 2,
    parameter int QUEUE_DEPTH         = 64
) (
    input  logic                           user_clk,
    input  logic                           user_reset_n,
    input  logic [C_DATA_WIDTH-1:0]        m_axis_cq_tdata,
    input  logic [AXI4_CQ_TUSER_WIDTH-1:0] m_axis_cq_tuser,
    input  logic [KEEP_WIDTH-1:0]          m_axis_cq_tkeep,
    input  logic                           m_axis_cq_tlast,
    input  logic                           m_axis_cq_tvalid,
    output logic                           m_axis_cq_tready,
    output logic [NUM_QUEUES*16-1:0]       sq_tail,
    output logic [NUM_QUEUES*16-1:0]       cq_head,
    output logic [NUM_QUEUES-1:0]          sq_tail_upd,
    output logic [NUM_QUEUES-1:0]          cq_head_upd,
    output logic                           db_err,
    output logic                           tlp_drop
);

    localparam int          NUM_DB    = 2 * NUM_QUEUES;
    localparam logic [15:0] DEPTH_LIM = 16'(QUEUE_DEPTH);

    // Handshake: a beat transfers on a rising user_clk edge where tvalid and tready are both high.
    // The stream is never back-pressured, so tready simply follows reset.
    assign m_axis_cq_tready = user_reset_n;

    state_t      state_q, state_d;
    cq_desc_t    desc_q;
    logic [15:0] db_q [NUM_DB];
    logic [15:0] db_d [NUM_DB];
    logic [NUM_DB-1:0] upd_q, upd_d;
    logic        err_q, err_d;
    logic        drop_q, drop_d;

    logic        beat;
    logic        sop;
    logic        disc;
    logic        tlast;
    logic        desc_ok;
    logic        any_upd;
    logic [15:0] cur0, cur1;
    logic [15:0] new0, new1;
    db_target_t  dw0, dw1;
    cq_desc_t    beat_desc;
    logic        unused_bits;

    assign beat  = m_axis_cq_tvalid && m_axis_cq_tready;
    assign sop   = m_axis_cq_tuser[TUSER_SOP_BIT];
    assign disc  = m_axis_cq_tuser[TUSER_DISC_BIT];
    assign tlast = m_axis_cq_tlast;

    assign beat_desc = '{dw_addr:     m_axis_cq_tdata[15:2],
                         dword_count: m_axis_cq_tdata[74:64],
                         first_be:    m_axis_cq_tuser[TUSER_FIRST_BE_LSB +: 4],
                         last_be:     m_axis_cq_tuser[TUSER_LAST_BE_LSB +: 4]};

    assign desc_ok = sop && !tlast && !disc &&
                     (m_axis_cq_tdata[78:75] == REQ_MEM_WR) &&
                     (m_axis_cq_tdata[114:112] == 3'd0) &&
                     ((beat_desc.dword_count == 11'd1) || (beat_desc.dword_count == 11'd2));

    db_addr_decode #(
        .NUM_QUEUES (NUM_QUEUES)
    ) u_decode (
        .dw_addr     (desc_q.dw_addr),
        .dword_count (desc_q.dword_count),
        .first_be    (desc_q.first_be),
        .last_be     (desc_q.last_be),
        .keep        (m_axis_cq_tkeep[1:0]),
        .dw0         (dw0),
        .dw1         (dw1)
    );

    always_comb begin
        state_d = state_q;
        upd_d   = '0;
        err_d   = 1'b0;
        drop_d  = 1'b0;
        any_upd = 1'b0;
        cur0    = '0;
        cur1    = '0;
        for (int j = 0; j < NUM_DB; j++) begin
            db_d[j] = db_q[j];
            if (dw0.idx == DB_IDX_W'(j)) cur0 = db_q[j];
            if (dw1.idx == DB_IDX_W'(j)) cur1 = db_q[j];
        end
        new0 = merge_db(cur0, m_axis_cq_tdata[15:0], dw0.be);
        new1 = merge_db(cur1, m_axis_cq_tdata[47:32], dw1.be);

        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    if (desc_ok)     state_d = ST_DATA;
                    else if (!tlast) state_d = ST_DROP;
                    else             drop_d  = 1'b1;
                end
            end
            ST_DATA: begin
                if (beat) begin
                    if (!disc) begin
                        if (dw0.hit) begin
                            if (new0 >= DEPTH_LIM) begin
                                err_d = 1'b1;
                            end else begin
                                any_upd = 1'b1;
                                for (int j = 0; j < NUM_DB; j++) begin
                                    if (dw0.idx == DB_IDX_W'(j)) begin
                                        db_d[j]  = new0;
                                        upd_d[j] = 1'b1;
                                    end
                                end
                            end
                        end
                        if (dw1.hit) begin
                            if (new1 >= DEPTH_LIM) begin
                                err_d = 1'b1;
                            end else begin
                                any_upd = 1'b1;
                                for (int j = 0; j < NUM_DB; j++) begin
                                    if (dw1.idx == DB_IDX_W'(j)) begin
                                        db_d[j]  = new1;
                                        upd_d[j] = 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    // A TLP that runs past its data beat reports the drop when ST_DROP sees tlast.
                    if (tlast) begin
                        state_d = ST_IDLE;
                        drop_d  = !any_upd;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (beat && tlast) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q <= ST_IDLE;
            desc_q  <= '0;
            upd_q   <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            for (int j = 0; j < NUM_DB; j++) db_q[j] <= '0;
        end else begin
            state_q <= state_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            for (int j = 0; j < NUM_DB; j++) db_q[j] <= db_d[j];
            if (state_q == ST_IDLE && beat && sop) desc_q <= beat_desc;
        end
    end

    for (genvar y = 0; y < NUM_QUEUES; y++) begin : g_pack
        assign sq_tail[16*y +: 16] = db_q[2*y];
        assign cq_head[16*y +: 16] = db_q[2*y+1];
        assign sq_tail_upd[y]      = upd_q[2*y];
        assign cq_head_upd[y]      = upd_q[2*y+1];
    end

    assign db_err   = err_q;
    assign tlp_drop = drop_q;

    assign unused_bits = ^{m_axis_cq_tdata[C_DATA_WIDTH-1:115], m_axis_cq_tdata[111:79],
                           m_axis_cq_tdata[63:48], m_axis_cq_tdata[31:16], m_axis_cq_tdata[1:0],
                           m_axis_cq_tuser[AXI4_CQ_TUSER_WIDTH-1:42], m_axis_cq_tuser[39:8],
                           m_axis_cq_tkeep[KEEP_WIDTH-1:2]};

endmodule

// File: tb/tb_doorbell_receiver.sv
// Self-checking bench for doorbell_receiver: directed doorbell scenarios, then random TLPs
// scored against a reference model of the doorbell register file and the pulse outputs.
module tb_doorbell_receiver;
    import nvme_pcie_pkg::*;

    localparam int NQ  = 2;
    localparam int NDB = 2 * NQ;

    logic          user_clk;
    logic          user_reset_n;
    logic [127:0]  m_axis_cq_tdata;
    logic [84:0]   m_axis_cq_tuser;
    logic [3:0]    m_axis_cq_tkeep;
    logic          m_axis_cq_tlast;
    logic          m_axis_cq_tvalid;
    logic          m_axis_cq_tready;
    logic [NQ*16-1:0] sq_tail;
    logic [NQ*16-1:0] cq_head;
    logic [NQ-1:0] sq_tail_upd;
    logic [NQ-1:0] cq_head_upd;
    logic          db_err;
    logic          tlp_drop;

    int checks = 0;
    int errors = 0;

    int model_db [NDB];
    int upd_cnt [NDB];
    int err_cnt  = 0;
    int drop_cnt = 0;
    int s_upd [NDB];
    int s_err;
    int s_drop;

    doorbell_receiver #(
        .C_DATA_WIDTH        (128),
        .AXI4_CQ_TUSER_WIDTH (85),
        .KEEP_WIDTH          (4),
        .NUM_QUEUES          (NQ),
        .QUEUE_DEPTH         (64)
    ) dut (
        .user_clk         (user_clk),
        .user_reset_n     (user_reset_n),
        .m_axis_cq_tdata  (m_axis_cq_tdata),
        .m_axis_cq_tuser  (m_axis_cq_tuser),
        .m_axis_cq_tkeep  (m_axis_cq_tkeep),
        .m_axis_cq_tlast  (m_axis_cq_tlast),
        .m_axis_cq_tvalid (m_axis_cq_tvalid),
        .m_axis_cq_tready (m_axis_cq_tready),
        .sq_tail          (sq_tail),
        .cq_head          (cq_head),
        .sq_tail_upd      (sq_tail_upd),
        .cq_head_upd      (cq_head_upd),
        .db_err           (db_err),
        .tlp_drop         (tlp_drop)
    );

    // Clock and reset
    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    // Pulse monitor: every high cycle of a pulse output counts once.
    initial for (int j = 0; j < NDB; j++) upd_cnt[j] = 0;
    always @(negedge user_clk) begin
        if (user_reset_n) begin
            for (int q = 0; q < NQ; q++) begin
                upd_cnt[2*q]   += int'(sq_tail_upd[q]);
                upd_cnt[2*q+1] += int'(cq_head_upd[q]);
            end
            err_cnt  += int'(db_err);
            drop_cnt += int'(tlp_drop);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dut_db(input int j);
        if (j % 2 == 0) return sq_tail[16*(j/2) +: 16];
        return cq_head[16*(j/2) +: 16];
    endfunction

    task automatic snap();
        for (int j = 0; j < NDB; j++) s_upd[j] = upd_cnt[j];
        s_err  = err_cnt;
        s_drop = drop_cnt;
    endtask

    task automatic verify(input string tag, input logic [NDB-1:0] exp_upd, input int exp_drop, input int exp_err);
        for (int j = 0; j < NDB; j++) begin
            check($sformatf("%s upd[%0d]", tag, j), upd_cnt[j] - s_upd[j], exp_upd[j]);
            check($sformatf("%s db[%0d]", tag, j), dut_db(j), model_db[j]);
        end
        check({tag, " tlp_drop"}, drop_cnt - s_drop, exp_drop);
        check({tag, " db_err"}, err_cnt - s_err, exp_err);
    endtask

    // Driver: one beat, held until the next rising edge, with junk on the bus afterwards.
    task automatic drive_beat(input logic [127:0] data, input logic [84:0] user,
                              input logic [3:0] keep, input logic last);
        m_axis_cq_tdata  = data;
        m_axis_cq_tuser  = user;
        m_axis_cq_tkeep  = keep;
        m_axis_cq_tlast  = last;
        m_axis_cq_tvalid = 1'b1;
        @(posedge user_clk);
        #1;
        m_axis_cq_tvalid = 1'b0;
        m_axis_cq_tdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
        m_axis_cq_tlast  = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge user_clk);
            #1;
        end
    endtask

    // Reference model plus driver for one whole TLP.
    task automatic send_tlp(input string tag, input logic [3:0] typ, input logic [2:0] bar,
                            input logic [10:0] cnt, input bit sop, input logic [63:0] addr,
                            input logic [3:0] fbe, input logic [3:0] lbe,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [3:0] keep, input bit disc, input int nbeats);
        logic [NDB-1:0] exp_upd;
        int exp_drop, exp_err, nupd, off, idx;
        logic [15:0] nv;
        logic [31:0] d;
        logic [3:0]  be;
        logic [127:0] data;
        logic [84:0]  user;

        exp_upd = '0;
        exp_err = 0;
        nupd    = 0;
        if (sop && typ == 4'b0001 && bar == 3'd0 && (cnt == 1 || cnt == 2) && nbeats >= 2) begin
            if (!disc) begin
                off = int'(addr[15:0]);
                for (int k = 0; k < int'(cnt); k++) begin
                    d   = (k == 0) ? d0 : d1;
                    be  = (k == 0) ? fbe : lbe;
                    idx = (off - 4096) / 4 + k;
                    if (off >= 4096 && idx < NDB && be[1:0] != 2'b00 && keep[k]) begin
                        nv = 16'(model_db[idx]);
                        if (be[0]) nv[7:0]  = d[7:0];
                        if (be[1]) nv[15:8] = d[15:8];
                        if (nv >= 64) begin
                            exp_err = 1;
                        end else begin
                            model_db[idx] = int'(nv);
                            exp_upd[idx]  = 1'b1;
                            nupd++;
                        end
                    end
                end
            end
            exp_drop = (nupd == 0 || nbeats > 2) ? 1 : 0;
        end else begin
            exp_drop = 1;
        end

        snap();
        data = {$urandom(), $urandom(), $urandom(), $urandom()};
        data[63:0]    = addr;
        data[74:64]   = cnt;
        data[78:75]   = typ;
        data[114:112] = bar;
        user = '0;
        user[3:0] = fbe;
        user[7:4] = lbe;
        user[40]  = sop;
        drive_beat(data, user, 4'hF, nbeats == 1);
        for (int b = 1; b < nbeats; b++) begin
            idle_cycles($urandom_range(0, 2));
            data = {$urandom(), $urandom(), $urandom(), $urandom()};
            user[40] = 1'b0;
            user[41] = 1'b0;
            if (b == 1) begin
                data[31:0]  = d0;
                data[63:32] = d1;
                user[41]    = disc;
            end
            drive_beat(data, user, (b == 1) ? keep : 4'hF, b == nbeats - 1);
        end
        idle_cycles(2);
        @(negedge user_clk);
        verify(tag, exp_upd, exp_drop, exp_err);
        #1;
    endtask

    initial begin
        logic [63:0]  addr;
        logic [31:0]  d0, d1;
        logic [127:0] data;
        logic [84:0]  user;
        int sel;

        user_reset_n     = 1'b0;
        m_axis_cq_tdata  = '0;
        m_axis_cq_tuser  = '0;
        m_axis_cq_tkeep  = '0;
        m_axis_cq_tlast  = 1'b0;
        m_axis_cq_tvalid = 1'b0;
        for (int j = 0; j < NDB; j++) model_db[j] = 0;

        #12;
        check("reset tready", m_axis_cq_tready, 0);
        check("reset sq_tail", sq_tail, 0);
        check("reset cq_head", cq_head, 0);
        check("reset pulses", {sq_tail_upd, cq_head_upd, db_err, tlp_drop}, 0);
        check("reset state", dut.state_q, ST_IDLE);
        idle_cycles(2);
        user_reset_n = 1'b1;
        idle_cycles(2);
        check("tready after reset", m_axis_cq_tready, 1);

        // Single-dword SQ0 tail write.
        send_tlp("sq0_write", 4'b0001, 3'd0, 11'd1, 1'b1, 64'h1000, 4'b0011, 4'b0000,
                 32'h0000_0005, 32'h0, 4'hF, 1'b0, 2);
        check("sq0 value", sq_tail[15:0], 16'd5);

        // Two-dword write at CQ1: second dword falls past the last doorbell.
        send_tlp("cq1_pair", 4'b0001, 3'd0, 11'd2, 1'b1, 64'h100C, 4'b0011, 4'b0011,
                 32'h0000_0003, 32'h0000_0007, 4'hF, 1'b0, 2);
        check("cq1 value", cq_head[31:16], 16'd3);

        // Value equal to the depth is rejected.
        send_tlp("sq1_overflow", 4'b0001, 3'd0, 11'd1, 1'b1, 64'h1008, 4'b0011, 4'b0000,
                 32'h0000_0040, 32'h0, 4'hF, 1'b0, 2);
        check("sq1 unchanged", sq_tail[31:16], 16'd0);

        // Rewrite of the same value still pulses; then both dwords of a pair land together.
        send_tlp("sq0_same", 4'b0001, 3'd0, 11'd1, 1'b1, 64'h1000, 4'b0001, 4'b0000,
                 32'h0000_0005, 32'h0, 4'hF, 1'b0, 2);
        send_tlp("sq1_cq1", 4'b0001, 3'd0, 11'd2, 1'b1, 64'h1008, 4'b0011, 4'b0011,
                 32'h0000_003F, 32'h0000_0000, 4'hF, 1'b0, 2);

        // MemRd in a single beat, then a three-dword MemWr spread over three beats.
        send_tlp("memrd", 4'b0000, 3'd0, 11'd1, 1'b1, 64'h1000, 4'b1111, 4'b0000,
                 32'h0, 32'h0, 4'hF, 1'b0, 1);
        send_tlp("count3", 4'b0001, 3'd0, 11'd3, 1'b1, 64'h1000, 4'b0011, 4'b0011,
                 32'h1, 32'h2, 4'hF, 1'b0, 3);

        // Discontinue on the data beat.
        send_tlp("discontinue", 4'b0001, 3'd0, 11'd1, 1'b1, 64'h1004, 4'b0011, 4'b0000,
                 32'h9, 32'h0, 4'hF, 1'b1, 2);

        // Reset between descriptor and data beat.
        data = '0;
        data[63:0]  = 64'h1004;
        data[74:64] = 11'd1;
        data[78:75] = 4'b0001;
        user = '0;
        user[3:0] = 4'b0011;
        user[40]  = 1'b1;
        drive_beat(data, user, 4'hF, 1'b0);
        #2;
        user_reset_n = 1'b0;
        for (int j = 0; j < NDB; j++) model_db[j] = 0;
        #1;
        check("midreset tready", m_axis_cq_tready, 0);
        check("midreset state", dut.state_q, ST_IDLE);
        check("midreset regs", {sq_tail, cq_head}, 0);
        idle_cycles(2);
        user_reset_n = 1'b1;
        idle_cycles(1);
        snap();
        data[31:0] = 32'h0000_000A;
        user[40]   = 1'b0;
        drive_beat(data, user, 4'hF, 1'b1);
        idle_cycles(2);
        @(negedge user_clk);
        verify("after_reset", '0, 1, 0);
        check("after_reset state", dut.state_q, ST_IDLE);
        #1;

        // Random traffic.
        for (int t = 0; t < 150; t++) begin
            addr = {$urandom(), $urandom()};
            sel  = $urandom_range(0, 9);
            if (sel == 0)      addr[15:0] = 16'h2000 + 16'(4 * $urandom_range(0, 3));
            else               addr[15:0] = 16'h0FFC + 16'(4 * $urandom_range(0, 6));
            d0 = $urandom();
            d1 = $urandom();
            if ($urandom_range(0, 7) != 0) d0[15:0] = 16'($urandom_range(0, 80));
            if ($urandom_range(0, 7) != 0) d1[15:0] = 16'($urandom_range(0, 80));
            sel = $urandom_range(0, 9);
            send_tlp($sformatf("rand%0d", t),
                     ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'b0001,
                     ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                     ($urandom_range(0, 9) == 0) ? 11'd3 : 11'($urandom_range(1, 2)),
                     $urandom_range(0, 14) != 0,
                     addr,
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     d0, d1,
                     ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
                     $urandom_range(0, 11) == 0,
                     (sel == 0) ? 1 : ((sel == 1) ? 3 : 2));
            idle_cycles($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
